// File: rtl/hsi_s_rx_ctrl_if.sv
// hsi_s_rx_ctrl_if
// Byte-stream bundle between the line decoder and the slave receive frame
// controller, plus the controller's outputs toward the slave transmit side.
//
// Handshake: a byte on d is taken exactly in a cycle where clk_en=1 and
// d_rdy=1; there is no back-pressure (the receiver always accepts).
// rx_d_rdy, rx_frame_end and rx_err are single-cycle pulses, with rx_d
// valid in the same cycle as rx_d_rdy.
//
// Signals:
//   clk_en       bit-rate enable
//   d, d_rdy     decoded byte and its strobe
//   rx_d         payload byte, rx_d_rdy its pulse
//   rx_flag      flag byte of the current or last frame
//   rx_frame_end good-frame pulse, rx_err abort pulse
//   rx_busy      frame in progress
//
// Modports: master = byte source / result consumer, slave = the controller.

interface hsi_s_rx_ctrl_if;
    logic       clk_en;
    logic [7:0] d;
    logic       d_rdy;
    logic [7:0] rx_d;
    logic       rx_d_rdy;
    logic [7:0] rx_flag;
    logic       rx_frame_end;
    logic       rx_err;
    logic       rx_busy;

    modport master (
        output clk_en, d, d_rdy,
        input  rx_d, rx_d_rdy, rx_flag, rx_frame_end, rx_err, rx_busy
    );

    modport slave (
        input  clk_en, d, d_rdy,
        output rx_d, rx_d_rdy, rx_flag, rx_frame_end, rx_err, rx_busy
    );
endinterface

// File: rtl/hsi_s_rx_ctrl.sv
// hsi_s_rx_ctrl
// Slave-side HSI receive frame controller. Parses FLAG, LEN, LEN payload
// bytes, CRC_H, CRC_L from the decoded byte stream, forwards payload bytes
// as they arrive and ends each frame with a one-cycle rx_frame_end (CRC16
// residue zero) or rx_err (bad length, bad CRC, or timeout).
//
// Parameters:
//   TIMEOUT_CYCLES  inter-byte timeout in clk_en cycles (timeout build only)
//   MAX_LEN         largest accepted LEN byte
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        hsi_s_rx_ctrl_if.slave (byte input, frame results)
//   state_dbg  current FSM state; 0 = IDLE, 1 = LEN, 2 = DATA,
//              3 = CRC_H, 4 = CRC_L, 5 = ERR
//
// Build option: define HSI_RX_TIMEOUT_EN to build the inter-byte timeout.
// Without it a stalled frame waits indefinitely.

module hsi_s_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_LEN        = 255
) (
    input  logic               clk,
    input  logic               rst,
    hsi_s_rx_ctrl_if.slave     bus,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CRC_H = 3'd3,
        S_CRC_L = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

    state_t      state;
    logic [15:0] crc;
    logic [7:0]  len_cnt;
    logic        accept;
    logic [15:0] crc_base;
    logic [15:0] crc_next;

    // CRC16-CCITT, polynomial 0x1021, MSB-first, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign accept    = bus.clk_en & bus.d_rdy;
    // The first byte of a frame always starts from the seed, even when it
    // arrives in the same cycle the previous frame's end pulse is out and
    // the register still holds the old residue.
    assign crc_base  = (state == S_IDLE) ? 16'hFFFF : crc;
    assign crc_next  = crc16_byte(crc_base, bus.d);
    assign state_dbg = state;

`ifdef HSI_RX_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            crc              <= 16'hFFFF;
            len_cnt          <= 8'd0;
            bus.rx_d         <= 8'd0;
            bus.rx_d_rdy     <= 1'b0;
            bus.rx_flag      <= 8'd0;
            bus.rx_frame_end <= 1'b0;
            bus.rx_err       <= 1'b0;
            bus.rx_busy      <= 1'b0;
`ifdef HSI_RX_TIMEOUT_EN
            to_cnt           <= 16'd0;
`endif
        end else begin
            bus.rx_d_rdy     <= 1'b0;
            bus.rx_frame_end <= 1'b0;
            bus.rx_err       <= 1'b0;

            if (accept) begin
                crc <= crc_next;
            end else if (state == S_IDLE) begin
                crc <= 16'hFFFF;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.rx_flag <= bus.d;
                        bus.rx_busy <= 1'b1;
                        state       <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_cnt <= bus.d;
                        if ({1'b0, bus.d} > MAX_LEN_C) begin
                            state <= S_ERR;
                        end else if (bus.d == 8'd0) begin
                            state <= S_CRC_H;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        bus.rx_d     <= bus.d;
                        bus.rx_d_rdy <= 1'b1;
                        len_cnt      <= len_cnt - 8'd1;
                        if (len_cnt == 8'd1) begin
                            state <= S_CRC_H;
                        end
                    end
                end
                S_CRC_H: begin
                    if (accept) begin
                        state <= S_CRC_L;
                    end
                end
                S_CRC_L: begin
                    if (accept) begin
                        if (crc_next == 16'h0000) begin
                            bus.rx_frame_end <= 1'b1;
                        end else begin
                            bus.rx_err <= 1'b1;
                        end
                        bus.rx_busy <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_ERR: begin
                    bus.rx_err  <= 1'b1;
                    bus.rx_busy <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef HSI_RX_TIMEOUT_EN
            // Counts idle clk_en cycles inside a frame; the cycle that would
            // take it to TIMEOUT_CYCLES aborts the frame instead.
            if (state == S_IDLE || state == S_ERR || accept) begin
                to_cnt <= 16'd0;
            end else if (bus.clk_en) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt      <= 16'd0;
                    bus.rx_err  <= 1'b1;
                    bus.rx_busy <= 1'b0;
                    state       <= S_IDLE;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_hsi_s_rx_ctrl.sv
// tb_hsi_s_rx_ctrl
// Bench for hsi_s_rx_ctrl. Frames are built from a bit-serial CRC16-CCITT
// model; expected payload streams and end events come from the frame rules
// (length limit, CRC residue) and are compared with what a negedge monitor
// collects from the DUT. Define HSI_RX_TIMEOUT_EN to also exercise the
// inter-byte timeout.

module tb_hsi_s_rx_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    hsi_s_rx_ctrl_if bus ();

    hsi_s_rx_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_LEN        (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- monitor ----------------
    logic [7:0] obs_pay_q[$];
    int         obs_evt_q[$];   // 1 = frame_end, 2 = err
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_d_rdy)     obs_pay_q.push_back(bus.rx_d);
        if (bus.rx_frame_end) obs_evt_q.push_back(1);
        if (bus.rx_err)       obs_evt_q.push_back(2);
        if (bus.rx_frame_end && bus.rx_err) both_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0] pl_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    // Bit-serial long division over everything currently in tx_q.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (tx_q[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ tx_q[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input logic [7:0] flag, input logic [7:0] crc_xor);
        logic [15:0] c;
        tx_q = {};
        tx_q.push_back(flag);
        tx_q.push_back(8'(pl_q.size()));
        foreach (pl_q[i]) tx_q.push_back(pl_q[i]);
        c = ref_crc();
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[7:0] ^ crc_xor);
    endtask

    // ---------------- drivers ----------------
    // Called off the clock edge; the byte is taken at the next posedge.
    task automatic drive_byte(input logic [7:0] b);
        bus.clk_en = 1'b1;
        bus.d      = b;
        bus.d_rdy  = 1'b1;
        @(posedge clk);
        #1;
        bus.d_rdy  = 1'b0;
        bus.d      = 8'($urandom);
    endtask

    // Idle cycles; strobes only appear with clk_en low, so they must be ignored.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.clk_en = 1'($urandom_range(0, 1));
            bus.d_rdy  = bus.clk_en ? 1'b0 : 1'($urandom_range(0, 1));
            bus.d      = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.clk_en = 1'b1;
        bus.d_rdy  = 1'b0;
    endtask

    task automatic send_tx(input int max_gap);
        foreach (tx_q[i]) begin
            drive_byte(tx_q[i]);
            if (max_gap > 0) idle_gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_pay_q = {};
        obs_evt_q = {};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.clk_en = 1'b0;
        bus.d_rdy  = 1'b0;
        bus.d      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.rx_d !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_d: got %h want 00", bus.rx_d); end
        tests_run++;
        if (bus.rx_d_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_d_rdy: got %b want 0", bus.rx_d_rdy); end
        tests_run++;
        if (bus.rx_flag !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_flag: got %h want 00", bus.rx_flag); end
        tests_run++;
        if (bus.rx_frame_end !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_end: got %b want 0", bus.rx_frame_end); end
        tests_run++;
        if (bus.rx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.rx_err); end
        tests_run++;
        if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
        tests_run++;
        if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_good_frame();
        clear_obs();
        pl_q = {8'h11, 8'h22, 8'h33};
        build_frame(8'hA5, 8'h00);
        foreach (tx_q[i]) begin
            drive_byte(tx_q[i]);
            @(negedge clk);
            if (i == 0) begin
                tests_run++;
                if ({bus.rx_busy, bus.rx_flag} !== {1'b1, 8'hA5}) begin
                    tests_failed++; $display("FAIL good_first_byte: busy/flag got %b/%h want 1/a5", bus.rx_busy, bus.rx_flag);
                end
            end else if (i >= 2 && i <= 4) begin
                tests_run++;
                if ({bus.rx_d_rdy, bus.rx_d} !== {1'b1, tx_q[i]}) begin
                    tests_failed++; $display("FAIL good_payload_%0d: rdy/d got %b/%h want 1/%h", i - 2, bus.rx_d_rdy, bus.rx_d, tx_q[i]);
                end
            end else if (i == 6) begin
                tests_run++;
                if ({bus.rx_frame_end, bus.rx_err, bus.rx_busy, bus.rx_flag} !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
                    tests_failed++; $display("FAIL good_end: end/err/busy/flag got %b/%b/%b/%h want 1/0/0/a5",
                                             bus.rx_frame_end, bus.rx_err, bus.rx_busy, bus.rx_flag);
                end
                tests_run++;
                if (state_dbg !== 3'd0) begin tests_failed++; $display("FAIL good_idle_at_end: state got %0d want 0", state_dbg); end
            end
        end
        @(negedge clk);
        tests_run++;
        if (bus.rx_frame_end !== 1'b0) begin tests_failed++; $display("FAIL good_end_one_cycle: got %b want 0", bus.rx_frame_end); end
        tests_run++;
        if (obs_pay_q.size() != 3 || obs_evt_q.size() != 1 || obs_evt_q[0] != 1) begin
            tests_failed++; $display("FAIL good_totals: payloads %0d events %0d want 3 payloads, one frame_end", obs_pay_q.size(), obs_evt_q.size());
        end
    endtask

    task automatic test_bad_crc();
        clear_obs();
        pl_q = {8'h11, 8'h22, 8'h33};
        build_frame(8'hA5, 8'h01);
        send_tx(3);
        wait_cycles(3);
        tests_run++;
        if (obs_pay_q.size() != 3 || obs_pay_q[0] !== 8'h11 || obs_pay_q[1] !== 8'h22 || obs_pay_q[2] !== 8'h33) begin
            tests_failed++; $display("FAIL bad_crc_payload: got %0d bytes want 11 22 33", obs_pay_q.size());
        end
        tests_run++;
        if (obs_evt_q.size() != 1 || obs_evt_q[0] != 2) begin
            tests_failed++; $display("FAIL bad_crc_event: got %0d events (first %0d) want a single err", obs_evt_q.size(),
                                     obs_evt_q.size() > 0 ? obs_evt_q[0] : 0);
        end
    endtask

    task automatic test_zero_len_b2b();
        clear_obs();
        pl_q = {};
        build_frame(8'h3C, 8'h00);
        foreach (tx_q[i]) drive_byte(tx_q[i]);
        @(negedge clk);
        tests_run++;
        if ({bus.rx_frame_end, bus.rx_err} !== 2'b10) begin
            tests_failed++; $display("FAIL zero_len_end: end/err got %b/%b want 1/0", bus.rx_frame_end, bus.rx_err);
        end
        tests_run++;
        if (obs_pay_q.size() != 0) begin tests_failed++; $display("FAIL zero_len_no_payload: got %0d bytes want 0", obs_pay_q.size()); end
        // Next FLAG goes in during the end-pulse cycle.
        pl_q = {8'h77};
        build_frame(8'h5A, 8'h00);
        drive_byte(tx_q[0]);
        @(negedge clk);
        tests_run++;
        if ({bus.rx_busy, bus.rx_flag} !== {1'b1, 8'h5A}) begin
            tests_failed++; $display("FAIL b2b_flag: busy/flag got %b/%h want 1/5a", bus.rx_busy, bus.rx_flag);
        end
        for (int i = 1; i < tx_q.size(); i++) drive_byte(tx_q[i]);
        wait_cycles(3);
        tests_run++;
        if (obs_evt_q.size() != 2 || obs_evt_q[0] != 1 || obs_evt_q[1] != 1 || obs_pay_q.size() != 1 || obs_pay_q[0] !== 8'h77) begin
            tests_failed++; $display("FAIL b2b_frames: events %0d payloads %0d want two frame_end and payload 77", obs_evt_q.size(), obs_pay_q.size());
        end
    endtask

    task automatic test_over_len();
        clear_obs();
        drive_byte(8'h81);
        drive_byte(8'h20);
        @(negedge clk);
        tests_run++;
        if (bus.rx_err !== 1'b0) begin tests_failed++; $display("FAIL over_len_early: err got %b want 0 one cycle after LEN", bus.rx_err); end
        @(negedge clk);
        tests_run++;
        if ({bus.rx_err, bus.rx_frame_end, bus.rx_busy} !== 3'b100) begin
            tests_failed++; $display("FAIL over_len_err: err/end/busy got %b/%b/%b want 1/0/0", bus.rx_err, bus.rx_frame_end, bus.rx_busy);
        end
        pl_q = {8'hC3, 8'hD4};
        build_frame(8'h42, 8'h00);
        send_tx(0);
        wait_cycles(3);
        tests_run++;
        if (bus.rx_flag !== 8'h42 || obs_evt_q.size() != 2 || obs_evt_q[0] != 2 || obs_evt_q[1] != 1 ||
            obs_pay_q.size() != 2 || obs_pay_q[0] !== 8'hC3 || obs_pay_q[1] !== 8'hD4) begin
            tests_failed++; $display("FAIL over_len_next_frame: flag %h events %0d payloads %0d want 42, err then frame_end, c3 d4",
                                     bus.rx_flag, obs_evt_q.size(), obs_pay_q.size());
        end
        // LEN exactly MAX_LEN is still legal.
        clear_obs();
        pl_q = {};
        for (int i = 0; i < MAX_LEN; i++) pl_q.push_back(8'($urandom));
        build_frame(8'h10, 8'h00);
        send_tx(1);
        wait_cycles(3);
        tests_run++;
        if (obs_evt_q.size() != 1 || obs_evt_q[0] != 1 || obs_pay_q.size() != MAX_LEN) begin
            tests_failed++; $display("FAIL max_len_frame: events %0d payloads %0d want one frame_end, %0d payloads",
                                     obs_evt_q.size(), obs_pay_q.size(), MAX_LEN);
        end
    endtask

    task automatic test_strobe_gating();
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            bus.clk_en = 1'b0; bus.d_rdy = 1'b1; bus.d = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.clk_en = 1'b1; bus.d_rdy = 1'b0;
        tests_run++;
        if ({bus.rx_busy, state_dbg, bus.rx_flag} !== {1'b0, 3'd0, 8'h10}) begin
            tests_failed++; $display("FAIL gating_idle: busy/state/flag got %b/%0d/%h want 0/0/10", bus.rx_busy, state_dbg, bus.rx_flag);
        end
        pl_q = {8'h01, 8'h02};
        build_frame(8'h66, 8'h00);
        drive_byte(tx_q[0]);
        for (int i = 0; i < 4; i++) begin
            bus.clk_en = 1'b0; bus.d_rdy = 1'b1; bus.d = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.clk_en = 1'b1; bus.d_rdy = 1'b0;
        for (int i = 1; i < tx_q.size(); i++) drive_byte(tx_q[i]);
        wait_cycles(3);
        tests_run++;
        if (obs_evt_q.size() != 1 || obs_evt_q[0] != 1 || obs_pay_q.size() != 2 || obs_pay_q[0] !== 8'h01 || obs_pay_q[1] !== 8'h02) begin
            tests_failed++; $display("FAIL gating_frame: events %0d payloads %0d want one frame_end, 01 02", obs_evt_q.size(), obs_pay_q.size());
        end
    endtask

`ifdef HSI_RX_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit found;
        clear_obs();
        drive_byte(8'h99);
        drive_byte(8'h05);
        drive_byte(8'hAB);
        drive_byte(8'hCD);
        bus.clk_en = 1'b1; bus.d_rdy = 1'b0;
        n = 0; found = 0;
        for (int i = 0; i < 4 * TIMEOUT && !found; i++) begin
            @(negedge clk);
            n++;
            if (bus.rx_err === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || n != TIMEOUT + 1) begin
            tests_failed++; $display("FAIL timeout_err: seen %0d after %0d cycles want 1 after %0d", found, n, TIMEOUT + 1);
        end
        @(negedge clk);
        tests_run++;
        if ({state_dbg, bus.rx_busy, bus.rx_err} !== {3'd0, 1'b0, 1'b0} || obs_evt_q.size() != 1 || obs_pay_q.size() != 2) begin
            tests_failed++; $display("FAIL timeout_idle: state %0d busy %b events %0d payloads %0d want 0 0 1 2",
                                     state_dbg, bus.rx_busy, obs_evt_q.size(), obs_pay_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        clear_obs();
        pl_q = {8'h5E, 8'h6F, 8'h70, 8'h81};
        build_frame(8'hE7, 8'h00);
        for (int i = 0; i < 4; i++) drive_byte(tx_q[i]);
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.rx_d, bus.rx_d_rdy, bus.rx_flag, bus.rx_frame_end, bus.rx_err, bus.rx_busy, state_dbg} !== 23'd0) begin
            tests_failed++; $display("FAIL reset_mid_outputs: d %h rdy %b flag %h end %b err %b busy %b state %0d want all 0",
                                     bus.rx_d, bus.rx_d_rdy, bus.rx_flag, bus.rx_frame_end, bus.rx_err, bus.rx_busy, state_dbg);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(2);
        tests_run++;
        if (obs_evt_q.size() != 0) begin tests_failed++; $display("FAIL reset_mid_silent: got %0d events want 0", obs_evt_q.size()); end
        clear_obs();
        build_frame(8'hE8, 8'h00);
        send_tx(2);
        wait_cycles(3);
        tests_run++;
        if (bus.rx_flag !== 8'hE8 || obs_evt_q.size() != 1 || obs_evt_q[0] != 1 || obs_pay_q.size() != 4 || obs_pay_q[3] !== 8'h81) begin
            tests_failed++; $display("FAIL reset_mid_recover: flag %h events %0d payloads %0d want e8, one frame_end, 4 payloads",
                                     bus.rx_flag, obs_evt_q.size(), obs_pay_q.size());
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] flag;
        int         len;
        int         exp_evt;
        int         bad;
        logic [7:0] x;
        for (int f = 0; f < 24; f++) begin
            clear_obs();
            flag = 8'($urandom);
            len  = $urandom_range(0, MAX_LEN + 4);
            exp_q = {};
            if (len > MAX_LEN) begin
                drive_byte(flag);
                drive_byte(8'(len));
                wait_cycles(3);
                exp_evt = 2;
            end else begin
                pl_q = {};
                for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
                x = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
                build_frame(flag, x);
                send_tx(3);
                wait_cycles(3);
                exp_q   = pl_q;
                exp_evt = (x == 8'h00) ? 1 : 2;
            end
            bad = (obs_pay_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < exp_q.size() && bad == 0; i++) if (obs_pay_q[i] !== exp_q[i]) bad = 1;
            tests_run++;
            if (bad != 0) begin
                tests_failed++; $display("FAIL rand_%0d_payload: got %0d bytes want %0d (len %0d)", f, obs_pay_q.size(), exp_q.size(), len);
            end
            tests_run++;
            if (obs_evt_q.size() != 1 || obs_evt_q[0] != exp_evt) begin
                tests_failed++; $display("FAIL rand_%0d_event: got %0d events (first %0d) want one event %0d", f, obs_evt_q.size(),
                                         obs_evt_q.size() > 0 ? obs_evt_q[0] : 0, exp_evt);
            end
            tests_run++;
            if (bus.rx_flag !== flag) begin tests_failed++; $display("FAIL rand_%0d_flag: got %h want %h", f, bus.rx_flag, flag); end
        end
        tests_run++;
        if (both_cnt != 0) begin tests_failed++; $display("FAIL end_and_err_together: got %0d cycles want 0", both_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_zero_len_b2b();
        test_over_len();
        test_strobe_gating();
`ifdef HSI_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hsi_s_rx_ctrl.md
# hsi_s_rx_ctrl

Slave-side HSI receive frame controller. It sits between the line decoder and the slave transmit controller. It takes decoded bytes, parses each frame (flag, length, payload, CRC16), and streams payload bytes out. At frame end it issues a one-cycle `rx_frame_end` with the latched `rx_flag`, or `rx_err` on any framing or CRC failure. The transmit side uses these pulses to start its response.

## Interface
- `TIMEOUT_CYCLES`, default 1024: inter-byte timeout, counted in `clk_en` cycles. Used only when the timeout feature is compiled in.
- `MAX_LEN`, default 255: largest accepted length byte. A larger length is a framing error.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  bit-rate enable. Byte strobes and the timeout counter advance only when it is 1.
- `d`  in  8  decoded byte from the line decoder.
- `d_rdy`  in  1  byte strobe. Sampled only when `clk_en`=1; one byte is accepted per such cycle.
- `rx_d`  out  8  payload byte.
- `rx_d_rdy`  out  1  one-cycle pulse; `rx_d` is valid in the same cycle.
- `rx_flag`  out  8  flag byte of the current or last frame.
- `rx_frame_end`  out  1  one-cycle pulse: frame received and CRC correct.
- `rx_err`  out  1  one-cycle pulse: frame aborted.
- `rx_busy`  out  1  high from the first byte of a frame until its end or abort.

## Operation
- Frame layout: FLAG, LEN, LEN payload bytes, CRC_H, CRC_L.
- CRC is CRC16-CCITT: polynomial 0x1021, initial value 0xFFFF, non-reflected, processed MSB-first per byte.
  - It runs over every byte of the frame, including CRC_H and CRC_L.
  - A good frame leaves a residue of 0x0000.
  - The CRC register is reset to 0xFFFF in IDLE.
- States:
  - IDLE: on an accepted byte, latch it into `rx_flag`, update the CRC, go to LEN.
  - LEN: latch the length counter.
    - If LEN > `MAX_LEN`, go to ERR.
    - If LEN = 0, go to CRC_H.
    - Otherwise go to DATA.
  - DATA: each accepted byte drives `rx_d` and pulses `rx_d_rdy`, then decrements the counter. When the counter reaches 0, go to CRC_H.
  - CRC_H: go to CRC_L on the next accepted byte.
  - CRC_L: on the accepted byte, check the residue.
    - Residue 0: pulse `rx_frame_end`.
    - Residue nonzero: pulse `rx_err`.
    - In both cases return to IDLE.
  - ERR: pulse `rx_err` for one cycle, then return to IDLE.
- Every byte updates the CRC, including the byte that causes an error. Payload bytes are forwarded before the CRC is known; the consumer discards them if `rx_err` follows.
- `rx_flag` holds its value until the next frame's first byte. `rx_d` holds its last payload byte.

## Timing
- Reset values: `rx_d`=0, `rx_d_rdy`=0, `rx_flag`=0, `rx_frame_end`=0, `rx_err`=0, `rx_busy`=0. State is IDLE, CRC=0xFFFF, counters 0.
- Payload latency: a byte accepted in cycle t appears as `rx_d`/`rx_d_rdy` in cycle t+1.
- Frame-end latency: if CRC_L is accepted in cycle t, `rx_frame_end` or `rx_err` is high in t+1 only. `rx_busy` drops in t+1.
- In the cycle the end pulse fires, the controller is already in IDLE. A byte accepted in that same cycle starts a new frame.
- `rx_frame_end` and `rx_err` are never high together.
- A `d_rdy` pulse with `clk_en`=0 is ignored.
- A reset asserted mid-frame discards the frame silently: no `rx_err`, outputs return to their reset values on the next edge.

## Configuration
- `HSI_RX_TIMEOUT_EN` defined:
  - A counter clears on every accepted byte and counts `clk_en` cycles while the state is not IDLE.
  - When it reaches `TIMEOUT_CYCLES`, the controller pulses `rx_err` in the next cycle and returns to IDLE.
- `HSI_RX_TIMEOUT_EN` not defined:
  - No counter is built. A stalled frame waits indefinitely in its current state.

## Test plan
- Good frame: FLAG=0xA5, LEN=0x03, payload 0x11 0x22 0x33, then CRC_H/CRC_L from the bench CRC16-CCITT model. Required: three `rx_d_rdy` pulses carrying 0x11, 0x22, 0x33; one `rx_frame_end` one cycle after CRC_L; `rx_flag`=0xA5; no `rx_err`.
- Corrupted CRC: same frame with CRC_L XOR 0x01. Required: three payload pulses, then a single `rx_err` and no `rx_frame_end`.
- Zero length and back-to-back frames:
  - FLAG=0x3C, LEN=0x00, correct CRC. Required: `rx_frame_end` with no `rx_d_rdy`.
  - Then send a second frame's FLAG in the end-pulse cycle. Required: it is accepted and `rx_flag` updates.
- Over-length and strobe gating:
  - `MAX_LEN`=16, LEN=0x20. Required: `rx_err` two cycles after LEN is accepted; the next byte is parsed as a new FLAG.
  - `d_rdy` with `clk_en`=0. Required: no state change.
- Timeout: with `HSI_RX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, stop after 2 payload bytes. Required: `rx_err` after 8 `clk_en` cycles, then state IDLE.
- Reset mid-frame: assert `rst` during DATA. Required: all outputs 0 on the next edge, no `rx_err`, and the next frame is received correctly.
